softex_tcdm_mem_responder: RTL and testbench

// - TCDM slave-side responder: terminates MP independent 64-bit TCDM request ports.
// - These are the ports produced by splitting the SoftEx accelerator's wide HCI master.
// - Backs them with a shared byte-enabled 64-bit word memory.
// - Returns read data and write acks in order, per port, honouring r_ready back-pressure.
// - Used as the memory-side model/endpoint in SoftEx cluster benches and FPGA bring-up.

---
 rtl/softex_tcdm_mem_responder_pkg.sv | 34 +++
 rtl/softex_tcdm_mem_responder_if.sv | 31 +++
 rtl/softex_tcdm_mem_responder_resp_fifo.sv | 77 +++++++
 rtl/softex_tcdm_mem_responder.sv | 119 +++++++++++
 tb/tb_softex_tcdm_mem_responder.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/softex_tcdm_mem_responder_pkg.sv
// Package: softex_pkg
// Shared constants and types for the SoftEx TCDM memory responder.
//  - TCDM_PORT_DW / TCDM_PORT_BW : data width and byte-enable width of one TCDM port
//  - TCDM_ID_W                   : transaction id width carried in a response entry
//  - tcdm_resp_t                 : one queued response {data, id, opc}
//  - lfsr_next()                 : one step of the 16-bit Galois stall LFSR
package softex_pkg;

    localparam int unsigned TCDM_PORT_DW = 64;
    localparam int unsigned TCDM_PORT_BW = 8;
    localparam int unsigned TCDM_ID_W    = 8;

    // Response entry; the id field is sized by TCDM_ID_W, so the responder's
    // ID_W parameter is expected to match it.
    typedef struct packed {
        logic [TCDM_PORT_DW-1:0] data;
        logic [TCDM_ID_W-1:0]    id;
        logic                    opc;
    } tcdm_resp_t;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        if (cur[0]) begin
            nxt = (cur >> 1) ^ LFSR_TAPS;
        end else begin
            nxt = cur >> 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/softex_tcdm_mem_responder_if.sv
// Interface: softex_tcdm_mem_responder_if
// Bundle of MP independent 64-bit TCDM ports (request + response channels).
//  - master modport: drives req/add/wen/be/data/id/r_ready, sees gnt and responses
//  - slave modport : the memory responder side
interface softex_tcdm_mem_responder_if #(
    parameter int unsigned MP   = 4,
    parameter int unsigned ID_W = 8
);
    logic [MP-1:0]            req;
    logic [MP-1:0]            gnt;
    logic [MP-1:0][31:0]      add;
    logic [MP-1:0]            wen;
    logic [MP-1:0][7:0]       be;
    logic [MP-1:0][63:0]      data;
    logic [MP-1:0][ID_W-1:0]  id;
    logic [MP-1:0]            r_ready;
    logic [MP-1:0]            r_valid;
    logic [MP-1:0][63:0]      r_data;
    logic [MP-1:0][ID_W-1:0]  r_id;
    logic [MP-1:0]            r_opc;

    modport master (
        output req, add, wen, be, data, id, r_ready,
        input  gnt, r_valid, r_data, r_id, r_opc
    );

    modport slave (
        input  req, add, wen, be, data, id, r_ready,
        output gnt, r_valid, r_data, r_id, r_opc
    );
endinterface

// File: rtl/softex_tcdm_mem_responder_resp_fifo.sv
// Module: softex_tcdm_resp_fifo
// Per-port in-order response queue of tcdm_resp_t entries.
//  - clk_i, rst_i : clock, asynchronous active-high reset (flushes the queue)
//  - push, push_data : enqueue (ignored when full)
//  - pop, pop_data   : dequeue (ignored when empty); pop_data is the current head
//  - full, empty, count : occupancy status
module softex_tcdm_resp_fifo
    import softex_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  tcdm_resp_t                 push_data,
    input  logic                       pop,
    output tcdm_resp_t                 pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tcdm_resp_t       store_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Qualified handshakes and status outputs.
    always_comb begin
        full     = (count_r == CNT_W'(DEPTH));
        empty    = (count_r == CNT_W'(0));
        push_s   = push && !full;
        pop_s    = pop && !empty;
        count    = count_r;
        pop_data = store_r[rd_ptr_r];
    end

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                store_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                store_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/softex_tcdm_mem_responder.sv
// Module: softex_tcdm_mem_responder
// Slave-side endpoint for MP independent 64-bit TCDM ports backed by one shared,
// byte-enabled word memory. Each port gets an in-order response FIFO.
//  - clk_i : clock
//  - rst_i : asynchronous active-high reset (FIFOs and LFSR; memory is kept)
//  - tcdm  : slave modport of softex_tcdm_mem_responder_if (requests + responses)
module softex_tcdm_mem_responder
    import softex_pkg::*;
#(
    parameter int unsigned MP         = 4,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned STALL_EN   = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    softex_tcdm_mem_responder_if.slave tcdm
);
    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 3;

    logic [TCDM_PORT_DW-1:0] mem_r [MEM_WORDS];
    logic [15:0]             lfsr_r;

    logic [31:0]      off_s       [MP];
    logic [AW-1:0]    word_s      [MP];
    logic [CNT_W-1:0] count_s     [MP];
    tcdm_resp_t       push_data_s [MP];
    tcdm_resp_t       head_s      [MP];
    logic [MP-1:0]    in_range_s;
    logic [MP-1:0]    gnt_s;
    logic [MP-1:0]    acc_s;
    logic [MP-1:0]    pop_s;
    logic [MP-1:0]    full_s;
    logic [MP-1:0]    empty_s;

    // Address decode, grant, response capture and response presentation.
    // The subtraction wraps for addresses below BASE_ADDR, so one unsigned
    // compare covers both range bounds.
    always_comb begin
        for (int i = 0; i < int'(MP); i++) begin
            off_s[i]      = tcdm.add[i] - BASE_ADDR;
            in_range_s[i] = ({1'b0, off_s[i]} < MEM_BYTES);
            word_s[i]     = off_s[i][AW+2:3];
            // Grant only from registered state: no dependency on req or r_ready.
            gnt_s[i] = !rst_i && (count_s[i] < CNT_W'(FIFO_DEPTH))
                       && !((STALL_EN != 0) && lfsr_r[4'(i)]);
            acc_s[i] = tcdm.req[i] && gnt_s[i];

            push_data_s[i].id  = TCDM_ID_W'(tcdm.id[i]);
            push_data_s[i].opc = !in_range_s[i];
            // Read sees the pre-write word: memory updates land after this edge.
            if (in_range_s[i] && tcdm.wen[i]) begin
                push_data_s[i].data = mem_r[word_s[i]];
            end else begin
                push_data_s[i].data = {TCDM_PORT_DW{1'b0}};
            end

            pop_s[i]        = !empty_s[i] && tcdm.r_ready[i];
            tcdm.gnt[i]     = gnt_s[i];
            tcdm.r_valid[i] = !empty_s[i];
            if (!empty_s[i]) begin
                tcdm.r_data[i] = head_s[i].data;
                tcdm.r_id[i]   = ID_W'(head_s[i].id);
                tcdm.r_opc[i]  = head_s[i].opc;
            end else begin
                tcdm.r_data[i] = 64'h0;
                tcdm.r_id[i]   = {ID_W{1'b0}};
                tcdm.r_opc[i]  = 1'b0;
            end
        end
    end

    // Byte-enabled memory writes; memory is deliberately not reset. Ports are
    // visited in ascending order so the highest-index writer of a byte wins.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(MP); i++) begin
            if (acc_s[i] && !tcdm.wen[i] && in_range_s[i]) begin
                for (int b = 0; b < int'(TCDM_PORT_BW); b++) begin
                    if (tcdm.be[i][b]) begin
                        mem_r[word_s[i]][b*8 +: 8] <= tcdm.data[i][b*8 +: 8];
                    end
                end
            end
        end
    end

    // Stall LFSR: free-running when stalls are enabled, otherwise held at seed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_r <= LFSR_SEED;
        end else if (STALL_EN != 0) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    for (genvar g = 0; g < int'(MP); g++) begin : g_port
        softex_tcdm_resp_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_resp_fifo (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .push      (acc_s[g] && !full_s[g]),
            .push_data (push_data_s[g]),
            .pop       (pop_s[g]),
            .pop_data  (head_s[g]),
            .full      (full_s[g]),
            .empty     (empty_s[g]),
            .count     (count_s[g])
        );
    end

endmodule

// File: tb/tb_softex_tcdm_mem_responder.sv
// Testbench for softex_tcdm_mem_responder. Two instances share stimulus:
// dut_a without grant stalls (grants fully predicted) and dut_b with LFSR
// stalls (grants observed, responses scoreboarded for loss/reorder/data).
module tb_softex_tcdm_mem_responder;
    import softex_pkg::*;

    localparam int          MP        = 4;
    localparam int          DEPTH     = 2;
    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] BASE      = 32'h1000_0000;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  id;
        logic        opc;
        logic        dc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    softex_tcdm_mem_responder_if #(.MP(MP), .ID_W(8)) ifa ();
    softex_tcdm_mem_responder_if #(.MP(MP), .ID_W(8)) ifb ();

    softex_tcdm_mem_responder #(.MP(MP), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE),
        .FIFO_DEPTH(DEPTH), .ID_W(8), .STALL_EN(0), .LFSR_SEED(16'hACE1))
        dut_a (.clk_i(clk), .rst_i(rst), .tcdm(ifa));

    softex_tcdm_mem_responder #(.MP(MP), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE),
        .FIFO_DEPTH(DEPTH), .ID_W(8), .STALL_EN(1), .LFSR_SEED(16'hACE1))
        dut_b (.clk_i(clk), .rst_i(rst), .tcdm(ifb));

    exp_t      exp_q     [2][MP][$];
    bit [63:0] mdl_mem   [2][MEM_WORDS];
    bit [7:0]  mdl_known [2][MEM_WORDS];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        grants_a = 0;

    logic [MP-1:0] s_req, s_wen, s_rdy;
    logic [31:0]   s_add  [MP];
    logic [7:0]    s_be   [MP];
    logic [63:0]   s_data [MP];
    logic [7:0]    s_id   [MP];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] init_val(input int w);
        return 64'h7766_5544_3322_1100 + 64'(w);
    endfunction

    function automatic void decode(input logic [31:0] a, output bit inr, output int w);
        longint unsigned av;
        av  = 64'(a);
        inr = (av >= 64'(BASE)) && (av < 64'(BASE) + 64'(8 * MEM_WORDS));
        w   = inr ? int'((av - 64'(BASE)) / 8) : 0;
    endfunction

    task automatic drive();
        ifa.req = s_req; ifa.wen = s_wen; ifa.r_ready = s_rdy;
        ifb.req = s_req; ifb.wen = s_wen; ifb.r_ready = s_rdy;
        for (int i = 0; i < MP; i++) begin
            ifa.add[i] = s_add[i]; ifa.be[i] = s_be[i]; ifa.data[i] = s_data[i]; ifa.id[i] = s_id[i];
            ifb.add[i] = s_add[i]; ifb.be[i] = s_be[i]; ifb.data[i] = s_data[i]; ifb.id[i] = s_id[i];
        end
    endtask

    task automatic idle();
        s_req = '0;
        for (int i = 0; i < MP; i++) begin
            s_add[i] = BASE; s_be[i] = 8'h00; s_data[i] = 64'h0; s_id[i] = 8'h00;
        end
    endtask

    task automatic set_port(input int p, input bit rd, input logic [31:0] a,
                            input logic [7:0] be, input logic [63:0] d, input logic [7:0] id);
        s_req[p] = 1'b1; s_wen[p] = rd; s_add[p] = a; s_be[p] = be; s_data[p] = d; s_id[p] = id;
    endtask

    // Effect of one clock edge on the behavioural model of instance s.
    task automatic model_edge(input int s, input logic [MP-1:0] acc, input logic [MP-1:0] pop);
        exp_t e;
        bit   inr;
        int   w;
        for (int i = 0; i < MP; i++)
            if (pop[i]) void'(exp_q[s][i].pop_front());
        for (int i = 0; i < MP; i++) begin
            if (acc[i]) begin
                decode(s_add[i], inr, w);
                e.id = s_id[i]; e.opc = !inr; e.data = 64'h0; e.dc = 1'b0;
                if (inr && s_wen[i]) begin
                    e.data = mdl_mem[s][w];
                    e.dc   = (mdl_known[s][w] != 8'hFF);
                end
                exp_q[s][i].push_back(e);
            end
        end
        for (int i = 0; i < MP; i++) begin
            decode(s_add[i], inr, w);
            if (acc[i] && !s_wen[i] && inr) begin
                for (int b = 0; b < 8; b++)
                    if (s_be[i][b]) mdl_mem[s][w][b*8 +: 8] = s_data[i][b*8 +: 8];
                mdl_known[s][w] = mdl_known[s][w] | s_be[i];
            end
        end
    endtask

    // Called just after a falling edge: check outputs, apply stimulus, advance one cycle.
    task automatic step();
        logic [MP-1:0] rv [2];
        logic [MP-1:0] gn [2];
        logic [MP-1:0] ro [2];
        logic [63:0]   rd [2][MP];
        logic [7:0]    ri [2][MP];
        logic [MP-1:0] acc_a, acc_b, pop_a, pop_b;
        exp_t          e;
        string         t;
        rv[0] = ifa.r_valid; gn[0] = ifa.gnt; ro[0] = ifa.r_opc;
        rv[1] = ifb.r_valid; gn[1] = ifb.gnt; ro[1] = ifb.r_opc;
        for (int i = 0; i < MP; i++) begin
            rd[0][i] = ifa.r_data[i]; ri[0][i] = ifa.r_id[i];
            rd[1][i] = ifb.r_data[i]; ri[1][i] = ifb.r_id[i];
        end
        for (int s = 0; s < 2; s++) begin
            t = (s == 0) ? "a" : "b";
            for (int i = 0; i < MP; i++) begin
                check($sformatf("%s_rvalid%0d", t, i), 64'(rv[s][i]), 64'(exp_q[s][i].size() != 0));
                if (exp_q[s][i].size() != 0) begin
                    e = exp_q[s][i][0];
                    check($sformatf("%s_rid%0d", t, i), 64'(ri[s][i]), 64'(e.id));
                    check($sformatf("%s_ropc%0d", t, i), 64'(ro[s][i]), 64'(e.opc));
                    if (!e.dc) check($sformatf("%s_rdata%0d", t, i), rd[s][i], e.data);
                end
                if (s == 0)
                    check($sformatf("a_gnt%0d", i), 64'(gn[0][i]), 64'(exp_q[0][i].size() < DEPTH));
                else if (exp_q[1][i].size() >= DEPTH)
                    check($sformatf("b_gnt_full%0d", i), 64'(gn[1][i]), 64'h0);
            end
        end
        drive();
        for (int i = 0; i < MP; i++) begin
            acc_a[i] = s_req[i] && (exp_q[0][i].size() < DEPTH);
            acc_b[i] = s_req[i] && gn[1][i];
            pop_a[i] = s_rdy[i] && (exp_q[0][i].size() != 0);
            pop_b[i] = s_rdy[i] && (exp_q[1][i].size() != 0);
        end
        grants_a += $countones(s_req & gn[0]);
        model_edge(0, acc_a, pop_a);
        model_edge(1, acc_b, pop_b);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset (already at a falling edge), check cleared outputs, release.
    task automatic reset_and_check();
        rst = 1'b1;
        s_req = '0;
        drive();
        #1;
        for (int i = 0; i < MP; i++) begin
            check($sformatf("rst_a_rvalid%0d", i), 64'(ifa.r_valid[i]), 64'h0);
            check($sformatf("rst_a_gnt%0d", i), 64'(ifa.gnt[i]), 64'h0);
            check($sformatf("rst_a_rdata%0d", i), ifa.r_data[i], 64'h0);
            check($sformatf("rst_a_rid%0d", i), 64'(ifa.r_id[i]), 64'h0);
            check($sformatf("rst_a_ropc%0d", i), 64'(ifa.r_opc[i]), 64'h0);
            check($sformatf("rst_b_rvalid%0d", i), 64'(ifb.r_valid[i]), 64'h0);
            check($sformatf("rst_b_gnt%0d", i), 64'(ifb.gnt[i]), 64'h0);
            exp_q[0][i].delete();
            exp_q[1][i].delete();
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16)       return BASE + 32'(r * 8) + 32'($urandom_range(0, 7));
        else if (r == 16) return BASE - 32'd8 + 32'($urandom_range(0, 7));
        else if (r == 17) return BASE + 32'h2000 + 32'($urandom_range(0, 7));
        else if (r == 18) return BASE + 32'h1FF8;
        else              return 32'h0FFF_FFF8;
    endfunction

    initial begin
        int pending;
        s_wen = '0;
        s_rdy = '1;
        idle();
        drive();
        @(negedge clk);
        reset_and_check();

        // Fill words 0..15 with a known pattern.
        for (int c = 0; c < 4; c++) begin
            idle();
            for (int p = 0; p < MP; p++)
                set_port(p, 1'b0, BASE + 32'((4 * c + p) * 8), 8'hFF, init_val(4 * c + p), 8'(c * 4 + p));
            step();
        end

        // Full-word write then read of the same word, one-cycle latency.
        idle(); set_port(0, 1'b0, BASE + 32'h8, 8'hFF, 64'hDEAD_BEEF_0123_4567, 8'h01); step();
        idle(); set_port(0, 1'b1, BASE + 32'h8, 8'h00, 64'h0, 8'h5A); step();
        check("wr_rd_valid", 64'(ifa.r_valid[0]), 64'h1);
        check("wr_rd_data", ifa.r_data[0], 64'hDEAD_BEEF_0123_4567);
        check("wr_rd_id", 64'(ifa.r_id[0]), 64'h5A);
        check("wr_rd_opc", 64'(ifa.r_opc[0]), 64'h0);

        // Same-cycle byte merge on word 2: higher port wins overlapping bytes.
        idle();
        set_port(1, 1'b0, BASE + 32'h10, 8'h0F, 64'h1111_1111_1111_1111, 8'h41);
        set_port(3, 1'b0, BASE + 32'h10, 8'h3C, 64'h2222_2222_2222_2222, 8'h43);
        step();
        idle(); set_port(0, 1'b1, BASE + 32'h10, 8'h00, 64'h0, 8'h77); step();
        check("merge_data", ifa.r_data[0], 64'h7766_2222_2222_1111);
        idle(); step(); step();

        // Back-pressure: two reads fill the FIFO, third is refused until a pop.
        s_rdy = '0;
        set_port(0, 1'b1, BASE + 32'h8, 8'h00, 64'h0, 8'h10); step();
        s_id[0] = 8'h11; step();
        check("bp_gnt_full", 64'(ifa.gnt[0]), 64'h0);
        s_id[0] = 8'h12; step();
        check("bp_gnt_still_full", 64'(ifa.gnt[0]), 64'h0);
        s_rdy = '1; step();
        check("bp_gnt_back", 64'(ifa.gnt[0]), 64'h1);
        check("bp_head_id", 64'(ifa.r_id[0]), 64'h11);
        step();
        idle(); step(); step(); step();

        // Out-of-range read below base and write past the end.
        set_port(0, 1'b1, 32'h0FFF_FFF8, 8'h00, 64'h0, 8'h20);
        set_port(1, 1'b0, BASE + 32'h2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h21);
        step();
        check("err_rd_opc", 64'(ifa.r_opc[0]), 64'h1);
        check("err_rd_data", ifa.r_data[0], 64'h0);
        check("err_wr_opc", 64'(ifa.r_opc[1]), 64'h1);
        check("err_wr_data", ifa.r_data[1], 64'h0);
        idle(); set_port(0, 1'b1, BASE, 8'h00, 64'h0, 8'h22); step();
        check("err_mem_intact", ifa.r_data[0], init_val(0));
        idle(); step(); step();

        // Throughput: back-to-back reads on every port with r_ready high.
        grants_a = 0;
        s_rdy = '1;
        for (int c = 0; c < 100; c++) begin
            for (int p = 0; p < MP; p++)
                set_port(p, 1'b1, BASE + 32'($urandom_range(0, 15) * 8), 8'h00, 64'h0, 8'($urandom));
            step();
        end
        check("tput_grants", 64'(grants_a), 64'd400);
        idle(); step(); step();

        // Randomized mixed traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < MP; p++) begin
                s_req[p]  = ($urandom_range(0, 3) != 0);
                s_wen[p]  = $urandom_range(0, 1);
                s_add[p]  = rand_addr();
                s_be[p]   = 8'($urandom);
                s_data[p] = {32'($urandom), 32'($urandom)};
                s_id[p]   = 8'($urandom);
                s_rdy[p]  = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        // Reset with two responses queued: they must never appear.
        idle(); s_rdy = '0; step(); step();
        set_port(0, 1'b1, BASE + 32'h18, 8'h00, 64'h0, 8'h30); step();
        s_id[0] = 8'h31; step();
        idle();
        check("pre_rst_queued", 64'(exp_q[0][0].size()), 64'd2);
        reset_and_check();
        check("rst_gnt_back", 64'(ifa.gnt), 64'hF);
        s_rdy = '1;
        for (int c = 0; c < 6; c++) step();

        // Drain with a bounded cycle budget; leftover entries mean lost responses.
        idle(); s_rdy = '1;
        for (int c = 0; c < 20; c++) begin
            pending = 0;
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < MP; i++) pending += exp_q[s][i].size();
            if (pending != 0) step();
        end
        pending = 0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < MP; i++) pending += exp_q[s][i].size();
        check("drain_empty", 64'(pending), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
